dpram_sync_param: RTL

// - Parametrised single-clock true dual-port RAM; next generation of the team's fixed 256x16 DPRAM.
// - Two independent read/write ports A and B with configurable width/depth, defined read-during-write
//   and write-collision behaviour, and a hardware memory-clear sequence after reset.
// - Used as a shared buffer between two datapath agents in the same clock domain.

---
 rtl/dpram_pkg.sv | 14 +
 rtl/dpram_clear_ctrl.sv | 56 +++++
 rtl/dpram_sync_param.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dpram_pkg.sv
// Shared types and constants for the parametrised dual-port RAM.
package dpram_pkg;

  // Clear-sequence controller states
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } dpram_state_e;

  // Read-during-write behaviour selectors for RDW_MODE
  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/dpram_clear_ctrl.sv
// Memory-clear sequencer: after reset, walks every address once so the RAM can be
// filled with the initialisation value, then parks in READY until the next reset.
module dpram_clear_ctrl
  import dpram_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              init_busy
);

  dpram_state_e      state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;

  // State and pointer registers; reset always restarts the sweep from address 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_CLEAR;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  // Next-state logic: one word cleared per cycle, leave CLEAR after the last address
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    clr_we     = 1'b0;
    init_busy  = 1'b0;
    case (state_reg)
      ST_CLEAR: begin
        init_busy = 1'b1;
        clr_we    = 1'b1;
        ptr_next  = ptr_reg + 1'b1;
        if (ptr_reg == '1) begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        state_next = ST_READY;
      end
      default: begin
        state_next = ST_CLEAR;
        ptr_next   = '0;
      end
    endcase
  end

  assign clr_addr = ptr_reg;

endmodule

// File: rtl/dpram_sync_param.sv
// Parametrised single-clock true dual-port RAM with defined read-during-write and
// write-collision behaviour (port A wins) and a hardware clear sequence after reset.
// Optional macro DPRAM_OUT_REG_EN adds an enable-gated output register per port
// (read latency 2) and delays the collision pulse by one cycle to match.
module dpram_sync_param
  import dpram_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 8,
  parameter int                RDW_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] data_i_a,
  output logic [DATA_W-1:0] data_o_a,
  input  logic              enb,
  input  logic              web,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] data_i_b,
  output logic [DATA_W-1:0] data_o_b,
  output logic              init_busy,
  output logic              collision
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic              acc_a, acc_b;
  logic              wr_a, wr_b_req, wr_b;
  logic              same_addr, coll_now;
  logic [DATA_W-1:0] old_a, old_b, new_a, new_b;
  logic [DATA_W-1:0] rd_a_next, rd_b_next;
  logic [DATA_W-1:0] rd_a_reg, rd_b_reg;
  logic              coll_reg;

  dpram_clear_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clk       (clk),
    .rst       (rst),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_busy (init_busy)
  );

  // Request qualification and arbitration: clear > port A > port B
  always_comb begin
    acc_a     = ena & ~init_busy;
    acc_b     = enb & ~init_busy;
    wr_a      = acc_a & wea;
    wr_b_req  = acc_b & web;
    same_addr = (addra == addrb);
    coll_now  = wr_a & wr_b_req & same_addr;
    wr_b      = wr_b_req & ~coll_now;
  end

  // Old word and post-write word at each port's address; the post-write view
  // includes a write from the other port to the same address
  always_comb begin
    old_a = mem[addra];
    old_b = mem[addrb];
    new_a = old_a;
    new_b = old_b;
    if (wr_a) begin
      new_a = data_i_a;
    end else if (wr_b && same_addr) begin
      new_a = data_i_b;
    end
    if (wr_a && same_addr) begin
      new_b = data_i_a;
    end else if (wr_b) begin
      new_b = data_i_b;
    end
  end

  // Read-during-write selection is a build-time choice
  generate
    if (RDW_MODE == RDW_WRITE_FIRST) begin : g_write_first
      assign rd_a_next = new_a;
      assign rd_b_next = new_b;
    end else begin : g_read_first
      assign rd_a_next = old_a;
      assign rd_b_next = old_b;
    end
  endgenerate

  // Array write port(s): the clear sweep has exclusive access while it runs
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= INIT_VAL;
    end else begin
      if (wr_a) begin
        mem[addra] <= data_i_a;
      end
      if (wr_b) begin
        mem[addrb] <= data_i_b;
      end
    end
  end

  // Read registers: held at 0 during clear, otherwise updated only on an access
  always_ff @(posedge clk) begin
    if (rst || init_busy) begin
      rd_a_reg <= '0;
      rd_b_reg <= '0;
      coll_reg <= 1'b0;
    end else begin
      if (acc_a) begin
        rd_a_reg <= rd_a_next;
      end
      if (acc_b) begin
        rd_b_reg <= rd_b_next;
      end
      coll_reg <= coll_now;
    end
  end

`ifdef DPRAM_OUT_REG_EN
  logic              en_a_d_reg, en_b_d_reg;
  logic [DATA_W-1:0] out_a_reg, out_b_reg;
  logic              coll_d_reg;

  // Second output stage, loaded only when the previous cycle carried an access
  always_ff @(posedge clk) begin
    if (rst) begin
      en_a_d_reg <= 1'b0;
      en_b_d_reg <= 1'b0;
      out_a_reg  <= '0;
      out_b_reg  <= '0;
      coll_d_reg <= 1'b0;
    end else begin
      en_a_d_reg <= acc_a;
      en_b_d_reg <= acc_b;
      if (en_a_d_reg) begin
        out_a_reg <= rd_a_reg;
      end
      if (en_b_d_reg) begin
        out_b_reg <= rd_b_reg;
      end
      coll_d_reg <= coll_reg;
    end
  end

  assign data_o_a  = out_a_reg;
  assign data_o_b  = out_b_reg;
  assign collision = coll_d_reg;
`else
  assign data_o_a  = rd_a_reg;
  assign data_o_b  = rd_b_reg;
  assign collision = coll_reg;
`endif

endmodule
